mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Multi-cycle load/store unit between the M stage and the data bus (DM, timers TC0/TC1, interrupt generator).
- Per request it checks address and alignment, raising AdEL/AdES.
- It issues one word-aligned bus transaction with byte enables and waits for ack, with a timeout that raises a bus error.
- It returns sign- or zero-extended load data.
- Parametrised successor of the single-cycle load extender, adding stores, unsigned loads, a bus handshake, flush and timeout.

Parameters:
DM_END, 32'h0000_2fff, last valid DM byte address (DM spans 0..DM_END).
TC0_BASE, 32'h0000_7f00, timer 0 base; window is 12 bytes.
TC1_BASE, 32'h0000_7f10, timer 1 base; window is 12 bytes.
IG_BASE, 32'h0000_7f20, interrupt generator base; window is 4 bytes.
TIMEOUT, 8, ACCESS cycles without ack before bus error (≥1).
EXC_ADEL, 5'd4, load address exception code.
EXC_ADES, 5'd5, store address exception code.
EXC_DBE, 5'd7, data bus error code.

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
req_valid  in  1  request present
req_ready  out  1  unit can accept (state IDLE)
req_op  in  4  1=lw 2=lh 3=lhu 4=lb 5=lbu 9=sw 10=sh 11=sb; any other value is a no-op
req_addr  in  32  byte address
req_wdata  in  32  store data (low bits for sb/sh)
flush  in  1  kill in-flight request
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  32  extended load data; 0 for stores and on exception
resp_exc  out  5  0 or exception code
bus_req  out  1  transaction request
bus_we  out  1  write
bus_be  out  4  byte enables
bus_addr  out  32  {req_addr[31:2],2'b00}
bus_wdata  out  32  lane-replicated store data
bus_ack  in  1  completes transaction, same cycle as rdata
bus_rdata  in  32  read word

Behaviour:
- Reset: state=IDLE, timeout counter=0. All outputs 0 except req_ready=1. Reset mid-transaction drops bus_req immediately with no response.
- Accept on req_valid & req_ready & op valid. Request is captured. An invalid op is ignored and the unit stays in IDLE.
- Checks at accept, load op (AdEL), first match wins:
  - lw with addr[1:0]≠0.
  - lh/lhu with addr[0]≠0.
  - lh/lhu/lb/lbu to a timer window.
  - address outside DM, TC0, TC1 and IG windows.
- Checks at accept, store op (AdES): same as loads, plus any store to TC0_BASE+8 or TC1_BASE+8 (read-only count registers).
- Exception at accept: go to RESP with exc set and rdata=0. No bus activity.
- IDLE→ACCESS: bus_req=1 and bus_addr/we/be/wdata are registered and held stable until ack.
  - be: w=4'b1111; h=4'b0011<<addr[1]*2; b=4'b0001<<addr[1:0].
  - wdata: sw=wdata; sh={2{wdata[15:0]}}; sb={4{wdata[7:0]}}.
- ACCESS with bus_ack: capture and extend rdata, then go to RESP.
  - Loads select the byte or half by addr[1:0]; lh/lb sign-extend, lhu/lbu zero-extend.
- ACCESS with no ack: counter increments. When counter==TIMEOUT-1 and no ack, go to RESP with EXC_DBE.
- RESP: resp_valid=1 for exactly one cycle, then IDLE. req_ready=0 in ACCESS and RESP, so the minimum latency is accept→resp of 2 cycles with a zero-wait ack.
- flush:
  - In IDLE it blocks acceptance that cycle.
  - In ACCESS it goes to DRAIN, which holds bus_req until ack or timeout and then goes to IDLE with no response.
  - In RESP it forces resp_valid=0 that cycle.
- ack arriving outside ACCESS/DRAIN is ignored.

Test Plan:
1. lb at addr 0x0000_0003, bus_rdata=0x80FF_1234, ack in the first ACCESS cycle → bus_be=4'b1000; resp on cycle 2 with rdata=0xFFFF_FF80 and exc=0.
2. lhu at addr 0x0000_0002, bus_rdata=0x8001_0000 → rdata=0x0000_8001. lh at the same address → rdata=0xFFFF_8001.
3. sh at addr 0x0000_0102 with wdata=0xAAAA_BEEF → bus_we=1, bus_be=4'b1100, bus_wdata=0xBEEF_BEEF, bus_addr=0x0000_0100.
4. lw at 0x0000_0002 → exc=4 with no bus_req. sb at 0x0000_7f04 → exc=5. sw at 0x0000_7f18 → exc=5. lw at 0x0000_3000 → exc=4.
5. With TIMEOUT=8 and ack never asserted → bus_req high for exactly 8 cycles, then resp_exc=7 and rdata=0.
6. Assert flush in the 2nd ACCESS cycle and ack 3 cycles later → no resp_valid, bus_req drops after ack, req_ready=1 the next cycle. Separately, assert reset mid-ACCESS → all outputs return to reset values immediately.

Source files
------------

// File: rtl/mem_access_unit.sv
// Multi-cycle load/store unit between the M stage and the data bus. It checks the
// address, runs one word-aligned bus transaction with a timeout and extends load data.
module mem_access_unit #(
  parameter logic [31:0] DM_END   = 32'h0000_2fff,
  parameter logic [31:0] TC0_BASE = 32'h0000_7f00,
  parameter logic [31:0] TC1_BASE = 32'h0000_7f10,
  parameter logic [31:0] IG_BASE  = 32'h0000_7f20,
  parameter int          TIMEOUT  = 8,
  parameter logic [4:0]  EXC_ADEL = 5'd4,
  parameter logic [4:0]  EXC_ADES = 5'd5,
  parameter logic [4:0]  EXC_DBE  = 5'd7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic        flush,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic [4:0]  resp_exc,
  output logic        bus_req,
  output logic        bus_we,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;
  localparam logic [1:0] S_DRAIN  = 2'd3;

  localparam int             CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [31:0]    TC0_CNT  = TC0_BASE + 32'd8;
  localparam logic [31:0]    TC1_CNT  = TC1_BASE + 32'd8;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [3:0]    op_q;
  logic [1:0]    lane_q;

  logic is_word, is_half, is_byte, is_store, op_valid;
  logic in_dm, in_tc, in_ig, ro_cnt, misalign, addr_exc, accept, cnt_done;
  logic [3:0]  be_c;
  logic [31:0] wdata_c, load_data;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign is_word  = (req_op == 4'd1) || (req_op == 4'd9);
  assign is_half  = (req_op == 4'd2) || (req_op == 4'd3) || (req_op == 4'd10);
  assign is_byte  = (req_op == 4'd4) || (req_op == 4'd5) || (req_op == 4'd11);
  assign is_store = req_op[3];
  assign op_valid = is_word || is_half || is_byte;

  // Unsigned subtraction wraps below the base, so one compare bounds each window.
  assign in_dm  = req_addr <= DM_END;
  assign in_tc  = ((req_addr - TC0_BASE) < 32'd12) || ((req_addr - TC1_BASE) < 32'd12);
  assign in_ig  = (req_addr - IG_BASE) < 32'd4;
  assign ro_cnt = is_store && ((req_addr[31:2] == TC0_CNT[31:2]) ||
                               (req_addr[31:2] == TC1_CNT[31:2]));

  assign misalign = (is_word && (req_addr[1:0] != 2'b00)) || (is_half && req_addr[0]);
  assign addr_exc = misalign || (!is_word && in_tc) || !(in_dm || in_tc || in_ig) || ro_cnt;

  assign accept     = (state == S_IDLE) && req_valid && !flush && op_valid;
  assign cnt_done   = (cnt == CNT_LAST);
  assign req_ready  = (state == S_IDLE);
  assign resp_valid = (state == S_RESP) && !flush;

  always_comb begin
    // NOTE: every signal driven here gets a default first so no latch is inferred.
    be_c    = 4'b1111;
    wdata_c = req_wdata;
    if (is_half) begin
      be_c    = req_addr[1] ? 4'b1100 : 4'b0011;
      wdata_c = {2{req_wdata[15:0]}};
    end else if (is_byte) begin
      be_c    = 4'b0001 << req_addr[1:0];
      wdata_c = {4{req_wdata[7:0]}};
    end
  end

  always_comb begin
    case (lane_q)
      2'd0:    byte_sel = bus_rdata[7:0];
      2'd1:    byte_sel = bus_rdata[15:8];
      2'd2:    byte_sel = bus_rdata[23:16];
      default: byte_sel = bus_rdata[31:24];
    endcase
    half_sel = lane_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (op_q)
      4'd1:    load_data = bus_rdata;
      4'd2:    load_data = {{16{half_sel[15]}}, half_sel};
      4'd3:    load_data = {16'd0, half_sel};
      4'd4:    load_data = {{24{byte_sel[7]}}, byte_sel};
      4'd5:    load_data = {24'd0, byte_sel};
      default: load_data = 32'd0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      op_q       <= 4'd0;
      lane_q     <= 2'd0;
      resp_rdata <= 32'd0;
      resp_exc   <= 5'd0;
      bus_req    <= 1'b0;
      bus_we     <= 1'b0;
      bus_be     <= 4'd0;
      bus_addr   <= 32'd0;
      bus_wdata  <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            op_q   <= req_op;
            lane_q <= req_addr[1:0];
            cnt    <= '0;
            if (addr_exc) begin
              state      <= S_RESP;
              resp_exc   <= is_store ? EXC_ADES : EXC_ADEL;
              resp_rdata <= 32'd0;
            end else begin
              state     <= S_ACCESS;
              bus_req   <= 1'b1;
              bus_we    <= is_store;
              bus_be    <= be_c;
              bus_addr  <= {req_addr[31:2], 2'b00};
              bus_wdata <= is_store ? wdata_c : 32'd0;
            end
          end
        end
        S_ACCESS: begin
          if (flush) begin
            // A flushed transaction still has to finish on the bus, silently.
            if (bus_ack || cnt_done) begin
              state   <= S_IDLE;
              bus_req <= 1'b0;
              cnt     <= '0;
            end else begin
              state <= S_DRAIN;
              cnt   <= cnt + 1'b1;
            end
          end else if (bus_ack) begin
            state      <= S_RESP;
            bus_req    <= 1'b0;
            cnt        <= '0;
            resp_rdata <= load_data;
            resp_exc   <= 5'd0;
          end else if (cnt_done) begin
            state      <= S_RESP;
            bus_req    <= 1'b0;
            cnt        <= '0;
            resp_rdata <= 32'd0;
            resp_exc   <= EXC_DBE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DRAIN: begin
          if (bus_ack || cnt_done) begin
            state   <= S_IDLE;
            bus_req <= 1'b0;
            cnt     <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state      <= S_IDLE;
          resp_rdata <= 32'd0;
          resp_exc   <= 5'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit: loads, stores, address
// exceptions, bus timeout, flush handling and asynchronous reset.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready;
  logic [3:0]  req_op;
  logic [31:0] req_addr, req_wdata;
  logic        flush;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [4:0]  resp_exc;
  logic        bus_req, bus_we;
  logic [3:0]  bus_be;
  logic [31:0] bus_addr, bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  int errors = 0;
  int checks = 0;

  mem_access_unit dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata), .flush(flush),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_exc(resp_exc),
    .bus_req(bus_req), .bus_we(bus_we), .bus_be(bus_be), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Presents one request for one cycle; afterwards the unit is in ACCESS or RESP.
  task automatic issue(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd);
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd;
    tick();
    req_valid = 1'b0; req_op = 4'd0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    req_valid = 1'b0; req_op = 4'd0; req_addr = 32'd0; req_wdata = 32'd0;
    flush = 1'b0; bus_ack = 1'b0; bus_rdata = 32'd0;
    #2;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b required=1", req_ready); end
    checks++; if ({bus_req, bus_we, bus_be, resp_valid} !== 7'd0) begin errors++;
      $display("FAIL reset_ctrl got=%b required=0", {bus_req, bus_we, bus_be, resp_valid}); end
    checks++; if ({bus_addr, bus_wdata, resp_rdata, resp_exc} !== 101'd0) begin errors++;
      $display("FAIL reset_data got=%h required=0", {bus_addr, bus_wdata, resp_rdata, resp_exc}); end
    tick();
    reset = 1'b0;
    tick();
  endtask

  // Load with the given ack delay; checks lane enables and extended data.
  task automatic run_load(input string tag, input logic [3:0] op, input logic [31:0] addr,
                          input logic [31:0] rd, input logic [3:0] exp_be, input logic [31:0] exp_rd);
    issue(op, addr, 32'd0);
    checks++; if (bus_req !== 1'b1 || req_ready !== 1'b0 || bus_we !== 1'b0) begin errors++;
      $display("FAIL %s_access got=req%b rdy%b we%b required=req1 rdy0 we0", tag, bus_req, req_ready, bus_we); end
    checks++; if (bus_be !== exp_be || bus_addr !== {addr[31:2], 2'b00}) begin errors++;
      $display("FAIL %s_bus got=be%b addr%h required=be%b addr%h", tag, bus_be, bus_addr, exp_be, {addr[31:2], 2'b00}); end
    bus_ack = 1'b1; bus_rdata = rd;
    tick();
    bus_ack = 1'b0; bus_rdata = 32'hdead_beef;
    checks++; if (resp_valid !== 1'b1 || resp_rdata !== exp_rd || resp_exc !== 5'd0 || bus_req !== 1'b0) begin errors++;
      $display("FAIL %s_resp got=v%b rd%h exc%0d req%b required=v1 rd%h exc0 req0", tag, resp_valid, resp_rdata, resp_exc, bus_req, exp_rd); end
    tick();
    checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++;
      $display("FAIL %s_done got=v%b rdy%b required=v0 rdy1", tag, resp_valid, req_ready); end
  endtask

  task automatic test_loads;
    run_load("lb3",  4'd4, 32'h0000_0003, 32'h80FF_1234, 4'b1000, 32'hFFFF_FF80);
    run_load("lhu2", 4'd3, 32'h0000_0002, 32'h8001_0000, 4'b1100, 32'h0000_8001);
    run_load("lh2",  4'd2, 32'h0000_0002, 32'h8001_0000, 4'b1100, 32'hFFFF_8001);
    run_load("lbu1", 4'd5, 32'h0000_0011, 32'h0000_9C00, 4'b0010, 32'h0000_009C);
    run_load("lw_ig", 4'd1, 32'h0000_7f20, 32'h1234_5678, 4'b1111, 32'h1234_5678);
  endtask

  task automatic test_store;
    issue(4'd10, 32'h0000_0102, 32'hAAAA_BEEF);
    for (int i = 0; i < 2; i++) begin
      checks++; if (bus_req !== 1'b1 || bus_we !== 1'b1 || bus_be !== 4'b1100) begin errors++;
        $display("FAIL sh_ctrl%0d got=req%b we%b be%b required=req1 we1 be1100", i, bus_req, bus_we, bus_be); end
      checks++; if (bus_wdata !== 32'hBEEF_BEEF || bus_addr !== 32'h0000_0100) begin errors++;
        $display("FAIL sh_data%0d got=wd%h addr%h required=wd beefbeef addr 00000100", i, bus_wdata, bus_addr); end
      if (i == 1) bus_ack = 1'b1;
      bus_rdata = 32'hffff_ffff;
      tick();
    end
    bus_ack = 1'b0;
    checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'd0 || resp_exc !== 5'd0) begin errors++;
      $display("FAIL sh_resp got=v%b rd%h exc%0d required=v1 rd0 exc0", resp_valid, resp_rdata, resp_exc); end
    tick();
    issue(4'd11, 32'h0000_0201, 32'h0000_00A5);
    checks++; if (bus_be !== 4'b0010 || bus_wdata !== 32'hA5A5_A5A5) begin errors++;
      $display("FAIL sb_bus got=be%b wd%h required=be0010 wd a5a5a5a5", bus_be, bus_wdata); end
    bus_ack = 1'b1; tick(); bus_ack = 1'b0; tick();
  endtask

  task automatic run_exc(input string tag, input logic [3:0] op, input logic [31:0] addr, input logic [4:0] exp_exc);
    issue(op, addr, 32'h1111_2222);
    checks++; if (resp_valid !== 1'b1 || resp_exc !== exp_exc || resp_rdata !== 32'd0 || bus_req !== 1'b0) begin errors++;
      $display("FAIL %s got=v%b exc%0d rd%h req%b required=v1 exc%0d rd0 req0", tag, resp_valid, resp_exc, resp_rdata, bus_req, exp_exc); end
    tick();
  endtask

  task automatic test_exceptions;
    run_exc("lw_misalign", 4'd1,  32'h0000_0002, 5'd4);
    run_exc("sb_timer",    4'd11, 32'h0000_7f04, 5'd5);
    run_exc("sw_tc1cnt",   4'd9,  32'h0000_7f18, 5'd5);
    run_exc("lw_hole",     4'd1,  32'h0000_3000, 5'd4);
    run_exc("lh_odd",      4'd2,  32'h0000_0001, 5'd4);
    run_exc("sw_past_ig",  4'd9,  32'h0000_7f24, 5'd5);
  endtask

  task automatic test_timeout;
    int n = 0;
    issue(4'd1, 32'h0000_0100, 32'd0);
    bus_rdata = 32'h5555_5555;
    for (int i = 0; i < 20; i++) begin
      if (!bus_req) break;
      n++;
      tick();
    end
    checks++; if (n !== 8) begin errors++; $display("FAIL timeout_len got=%0d required=8", n); end
    checks++; if (resp_valid !== 1'b1 || resp_exc !== 5'd7 || resp_rdata !== 32'd0) begin errors++;
      $display("FAIL timeout_resp got=v%b exc%0d rd%h required=v1 exc7 rd0", resp_valid, resp_exc, resp_rdata); end
    tick();
  endtask

  task automatic test_flush;
    int seen = 0;
    // flush blocks acceptance in IDLE, and an invalid op is ignored
    req_valid = 1'b1; req_op = 4'd1; req_addr = 32'h40; flush = 1'b1;
    tick();
    flush = 1'b0; req_op = 4'd7;
    tick();
    req_valid = 1'b0; req_op = 4'd0;
    checks++; if (req_ready !== 1'b1 || bus_req !== 1'b0 || resp_valid !== 1'b0) begin errors++;
      $display("FAIL idle_block got=rdy%b req%b v%b required=rdy1 req0 v0", req_ready, bus_req, resp_valid); end
    // flush in the second ACCESS cycle, ack three cycles later
    issue(4'd1, 32'h0000_0010, 32'd0);
    tick();
    flush = 1'b1;
    if (resp_valid) seen++;
    tick();
    flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (bus_req !== 1'b1) begin errors++; $display("FAIL drain_hold%0d got=%b required=1", i, bus_req); end
      if (resp_valid) seen++;
      if (i == 2) bus_ack = 1'b1;
      tick();
    end
    bus_ack = 1'b0;
    if (resp_valid) seen++;
    checks++; if (bus_req !== 1'b0 || req_ready !== 1'b1) begin errors++;
      $display("FAIL drain_end got=req%b rdy%b required=req0 rdy1", bus_req, req_ready); end
    tick();
    if (resp_valid) seen++;
    checks++; if (seen !== 0) begin errors++; $display("FAIL drain_noresp got=%0d required=0", seen); end
    // flush while in RESP suppresses the pulse
    issue(4'd1, 32'h0000_0002, 32'd0);
    flush = 1'b1;
    #1;
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL resp_flush got=%b required=0", resp_valid); end
    tick();
    flush = 1'b0;
    checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin errors++;
      $display("FAIL resp_flush_idle got=rdy%b v%b required=rdy1 v0", req_ready, resp_valid); end
  endtask

  task automatic test_reset_mid;
    issue(4'd9, 32'h0000_0200, 32'hCAFE_F00D);
    checks++; if (bus_req !== 1'b1 || bus_wdata !== 32'hCAFE_F00D) begin errors++;
      $display("FAIL mid_pre got=req%b wd%h required=req1 wd cafef00d", bus_req, bus_wdata); end
    #1 reset = 1'b1;
    #1;
    checks++; if (bus_req !== 1'b0 || req_ready !== 1'b1 || resp_valid !== 1'b0) begin errors++;
      $display("FAIL mid_reset_ctrl got=req%b rdy%b v%b required=req0 rdy1 v0", bus_req, req_ready, resp_valid); end
    checks++; if ({bus_we, bus_be, bus_addr, bus_wdata} !== 69'd0) begin errors++;
      $display("FAIL mid_reset_bus got=%h required=0", {bus_we, bus_be, bus_addr, bus_wdata}); end
    #1 reset = 1'b0;
    tick();
    checks++; if (resp_valid !== 1'b0 || bus_req !== 1'b0) begin errors++;
      $display("FAIL mid_after got=v%b req%b required=v0 req0", resp_valid, bus_req); end
  endtask

  initial begin
    test_reset();
    test_loads();
    test_store();
    test_exceptions();
    test_timeout();
    test_flush();
    run_load("back_to_back", 4'd1, 32'h0000_2ffc, 32'h0BAD_F00D, 4'b1111, 32'h0BAD_F00D);
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
